// File: rtl/cm_arb_agent_if.sv
// Bundle of the cm_arb_agent handshake and arbiter signals.
//   req_vld/req_rdy/req_prio   : per-channel upstream request port
//   arb_req/arb_weight         : request/weight vector towards the arbiter
//   arb_vld/arb_gnt            : arbiter result (granted index)
//   gnt_vld/gnt_idx/gnt_onehot : downstream grant port, gnt_rdy accepts it
//   drop                       : pulse when an arbiter result was discarded
// slave is the agent side, master the environment (upstream/arbiter/downstream).
interface cm_arb_agent_if #(
    parameter int unsigned DCNT   = 4,
    parameter int unsigned DWIDTH = 8
);
    localparam int unsigned IDX_WIDTH = (DCNT > 1) ? $clog2(DCNT) : 1;

    logic [DCNT-1:0]              req_vld;
    logic [DCNT-1:0]              req_rdy;
    logic [DCNT-1:0][DWIDTH-1:0]  req_prio;
    logic [DCNT-1:0]              arb_req;
    logic [DCNT-1:0][DWIDTH-1:0]  arb_weight;
    logic                         arb_vld;
    logic [IDX_WIDTH-1:0]         arb_gnt;
    logic                         gnt_vld;
    logic [IDX_WIDTH-1:0]         gnt_idx;
    logic [DCNT-1:0]              gnt_onehot;
    logic                         gnt_rdy;
    logic                         drop;

    modport slave (
        input  req_vld, req_prio, arb_vld, arb_gnt, gnt_rdy,
        output req_rdy, arb_req, arb_weight, gnt_vld, gnt_idx, gnt_onehot, drop
    );

    modport master (
        output req_vld, req_prio, arb_vld, arb_gnt, gnt_rdy,
        input  req_rdy, arb_req, arb_weight, gnt_vld, gnt_idx, gnt_onehot, drop
    );
endinterface

// File: rtl/cm_arb_agent.sv
// Requester-side agent for a weighted max-priority arbiter.
// Holds one pending request per channel, ages waiting weights (saturating),
// takes arbiter grants for pending channels into a one-entry downstream slot
// and discards stale or unplaceable results with a one-cycle drop pulse.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : cm_arb_agent_if.slave (request, arbiter and grant ports)
module cm_arb_agent #(
    parameter int unsigned DCNT     = 4,
    parameter int unsigned DWIDTH   = 8,
    parameter int unsigned REG_CNT  = 2,
    parameter int unsigned AGE_STEP = 1
) (
    input  logic           clk,
    input  logic           rst,
    cm_arb_agent_if.slave  bus
);
    localparam int unsigned IDX_WIDTH = (DCNT > 1) ? $clog2(DCNT) : 1;
    localparam int unsigned HWIDTH    = (REG_CNT > 0) ? $clog2(REG_CNT + 1) : 1;
    localparam logic [DWIDTH-1:0] WMAX = '1;

    logic [DCNT-1:0]             pending_q, pending_d;
    logic [DCNT-1:0][DWIDTH-1:0] weight_q, weight_d;
    logic [DCNT-1:0][HWIDTH-1:0] holdoff_q, holdoff_d;
    logic                        gnt_vld_q, gnt_vld_d;
    logic [IDX_WIDTH-1:0]        gnt_idx_q, gnt_idx_d;
    logic                        drop_q, drop_d;

    logic [DCNT-1:0]             req_rdy;
    logic [DCNT-1:0]             hit;
    logic [DCNT-1:0]             accept;
    logic [DCNT-1:0]             granted;
    logic [DCNT-1:0][DWIDTH:0]   aged;
    logic                        slot_free;
    logic                        take;
    logic [DCNT-1:0]             onehot;

    always_comb begin
        slot_free = !gnt_vld_q || bus.gnt_rdy;
        // Out-of-range indices never match a channel and therefore fall through to drop.
        for (int unsigned k = 0; k < DCNT; k++) begin
            hit[k] = bus.arb_vld && (bus.arb_gnt == IDX_WIDTH'(k));
        end
        take    = slot_free && |(hit & pending_q);
        granted = take ? hit : '0;
        drop_d  = bus.arb_vld && !take;

        for (int unsigned k = 0; k < DCNT; k++) begin
            req_rdy[k]   = !pending_q[k] && (holdoff_q[k] == '0);
            accept[k]    = bus.req_vld[k] && req_rdy[k];
            aged[k]      = {1'b0, weight_q[k]} + (DWIDTH + 1)'(AGE_STEP);
            pending_d[k] = pending_q[k];
            weight_d[k]  = weight_q[k];
            holdoff_d[k] = holdoff_q[k];
            if (holdoff_q[k] != '0) begin
                holdoff_d[k] = holdoff_q[k] - HWIDTH'(1);
            end
            if (granted[k]) begin
                // Holdoff covers results still in the arbiter pipeline for this request.
                pending_d[k] = 1'b0;
                weight_d[k]  = '0;
                holdoff_d[k] = HWIDTH'(REG_CNT);
            end else if (accept[k]) begin
                pending_d[k] = 1'b1;
                weight_d[k]  = bus.req_prio[k];
            end else if (pending_q[k]) begin
                weight_d[k] = aged[k][DWIDTH] ? WMAX : aged[k][DWIDTH-1:0];
            end
        end

        gnt_vld_d = gnt_vld_q;
        gnt_idx_d = gnt_idx_q;
        if (take) begin
            gnt_vld_d = 1'b1;
            gnt_idx_d = bus.arb_gnt;
        end else if (bus.gnt_rdy) begin
            gnt_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            weight_q  <= '0;
            holdoff_q <= '0;
            gnt_vld_q <= 1'b0;
            gnt_idx_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            weight_q  <= weight_d;
            holdoff_q <= holdoff_d;
            gnt_vld_q <= gnt_vld_d;
            gnt_idx_q <= gnt_idx_d;
            drop_q    <= drop_d;
        end
    end

    always_comb begin
        onehot = '0;
        for (int unsigned k = 0; k < DCNT; k++) begin
            onehot[k] = gnt_vld_q && (gnt_idx_q == IDX_WIDTH'(k));
        end
    end

    assign bus.req_rdy    = req_rdy;
    assign bus.arb_req    = pending_q;
    assign bus.arb_weight = weight_q;
    assign bus.gnt_vld    = gnt_vld_q;
    assign bus.gnt_idx    = gnt_idx_q;
    assign bus.gnt_onehot = onehot;
    assign bus.drop       = drop_q;
endmodule

// File: tb/tb_cm_arb_agent.sv
// Randomised and directed bench for cm_arb_agent with a behavioural reference
// model, a pipelined max-weight arbiter model and a grant scoreboard.
module tb_cm_arb_agent;
    localparam int unsigned DCNT     = 5;
    localparam int unsigned DWIDTH   = 8;
    localparam int unsigned REG_CNT  = 2;
    localparam int unsigned AGE_STEP = 1;
    localparam int unsigned IW       = 3;
    localparam int          WMAX     = 255;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cm_arb_agent_if #(.DCNT(DCNT), .DWIDTH(DWIDTH)) bus ();

    cm_arb_agent #(
        .DCNT(DCNT), .DWIDTH(DWIDTH), .REG_CNT(REG_CNT), .AGE_STEP(AGE_STEP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Reference model state (what the agent should hold right now).
    int m_pend[DCNT];
    int m_wt[DCNT];
    int m_hold[DCNT];
    int m_vld, m_idx, m_drop;
    int exp_q[$];

    // Arbiter model pipeline: entry REG_CNT is the result presented this cycle.
    int pv[REG_CNT+1];
    int pi[REG_CNT+1];

    // Stimulus controls.
    int s_vld[DCNT];
    int s_prio[DCNT];
    int s_rdy, s_rst;
    int arb_mode;  // 0: arbiter model, 1: forced o_vld/o_gnt, 2: silent
    int o_vld, o_gnt;

    int n_chk, n_pass;
    int mon_on;
    int cnt_g1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Drive one cycle of stimulus, advance the model, return at posedge+1.
    task automatic tick();
        int av, ag, best, take, slot, ready;
        int n_pend[DCNT];
        int n_wt[DCNT];
        int n_hold[DCNT];
        int n_vld, n_idx, n_drop;

        for (int i = REG_CNT; i > 0; i--) begin
            pv[i] = pv[i-1];
            pi[i] = pi[i-1];
        end
        best = -1;
        for (int k = 0; k < DCNT; k++)
            if (m_pend[k] != 0 && (best < 0 || m_wt[k] > m_wt[best])) best = k;
        pv[0] = (best >= 0) ? 1 : 0;
        pi[0] = (best >= 0) ? best : 0;

        case (arb_mode)
            0:       begin av = pv[REG_CNT]; ag = pi[REG_CNT]; end
            1:       begin av = o_vld;       ag = o_gnt;       end
            default: begin av = 0;           ag = 0;           end
        endcase

        rst = s_rst[0];
        for (int k = 0; k < DCNT; k++) begin
            bus.req_vld[k]  = s_vld[k][0];
            bus.req_prio[k] = DWIDTH'(s_prio[k]);
        end
        bus.arb_vld = av[0];
        bus.arb_gnt = IW'(ag);
        bus.gnt_rdy = s_rdy[0];

        slot = (m_vld == 0 || s_rdy != 0) ? 1 : 0;
        take = 0;
        if (av != 0 && ag < DCNT) begin
            if (m_pend[ag] != 0 && slot != 0) take = 1;
        end
        for (int k = 0; k < DCNT; k++) begin
            ready     = (m_pend[k] == 0 && m_hold[k] == 0) ? 1 : 0;
            n_pend[k] = m_pend[k];
            n_wt[k]   = m_wt[k];
            n_hold[k] = (m_hold[k] > 0) ? m_hold[k] - 1 : 0;
            if (take != 0 && ag == k) begin
                n_pend[k] = 0;
                n_wt[k]   = 0;
                n_hold[k] = REG_CNT;
            end else begin
                if (m_pend[k] != 0) n_wt[k] = (m_wt[k] + int'(AGE_STEP) > WMAX) ? WMAX
                                                                              : m_wt[k] + int'(AGE_STEP);
                if (s_vld[k] != 0 && ready != 0) begin
                    n_pend[k] = 1;
                    n_wt[k]   = s_prio[k];
                end
            end
        end
        n_vld  = (take != 0) ? 1 : ((s_rdy != 0) ? 0 : m_vld);
        n_idx  = (take != 0) ? ag : m_idx;
        n_drop = (av != 0 && take == 0) ? 1 : 0;
        if (take != 0) exp_q.push_back(ag);

        if (s_rst != 0) begin
            for (int k = 0; k < DCNT; k++) begin
                n_pend[k] = 0;
                n_wt[k]   = 0;
                n_hold[k] = 0;
            end
            n_vld  = 0;
            n_idx  = 0;
            n_drop = 0;
            exp_q.delete();
        end

        @(posedge clk);
        #1;
        for (int k = 0; k < DCNT; k++) begin
            m_pend[k] = n_pend[k];
            m_wt[k]   = n_wt[k];
            m_hold[k] = n_hold[k];
        end
        m_vld  = n_vld;
        m_idx  = n_idx;
        m_drop = n_drop;
    endtask

    // Monitor: per-cycle state comparison plus scoreboard pop on grant handshake.
    always @(negedge clk) begin
        int e;
        if (mon_on != 0) begin
            chk("gnt_vld", int'(bus.gnt_vld), m_vld);
            chk("drop", int'(bus.drop), m_drop);
            chk("onehot", int'(bus.gnt_onehot), (m_vld != 0) ? (1 << m_idx) : 0);
            for (int k = 0; k < DCNT; k++) begin
                chk($sformatf("req_rdy%0d", k), int'(bus.req_rdy[k]),
                    (m_pend[k] == 0 && m_hold[k] == 0) ? 1 : 0);
                chk($sformatf("arb_req%0d", k), int'(bus.arb_req[k]), m_pend[k]);
                chk($sformatf("weight%0d", k), int'(bus.arb_weight[k]), m_wt[k]);
            end
            if (bus.gnt_vld && bus.gnt_rdy && !rst) begin
                chk("sb_has_entry", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("gnt_idx", int'(bus.gnt_idx), e);
                    if (bus.gnt_idx == IW'(1)) cnt_g1++;
                end
            end
        end
    end

    task automatic clr_vld();
        for (int k = 0; k < DCNT; k++) s_vld[k] = 0;
    endtask

    initial begin
        int start, r;
        n_chk = 0; n_pass = 0; mon_on = 0; cnt_g1 = 0;
        m_vld = 0; m_idx = 0; m_drop = 0;
        for (int k = 0; k < DCNT; k++) begin
            m_pend[k] = 0; m_wt[k] = 0; m_hold[k] = 0; s_vld[k] = 0; s_prio[k] = 0;
        end
        for (int i = 0; i <= REG_CNT; i++) begin
            pv[i] = 0; pi[i] = 0;
        end
        s_rdy = 1; s_rst = 1; arb_mode = 2; o_vld = 0; o_gnt = 0;
        tick();
        tick();
        mon_on = 1;
        s_rst = 0;
        chk("rst_rdy", int'(bus.req_rdy), (1 << DCNT) - 1);

        // Single request on ch2 through the arbiter model.
        arb_mode = 0;
        s_vld[2] = 1; s_prio[2] = 5;
        tick();
        clr_vld();
        repeat (8) tick();

        // ch1 waits with no grants: weight must saturate, not wrap.
        arb_mode = 2;
        s_vld[1] = 1; s_prio[1] = 10;
        tick();
        clr_vld();
        repeat (250) tick();
        chk("ch1_saturated", int'(bus.arb_weight[1]), WMAX);
        arb_mode = 0;
        repeat (8) tick();

        // Starvation: ch0 re-requests at 200, ch1 at 10 must still win.
        s_vld[0] = 1; s_prio[0] = 200;
        s_vld[1] = 1; s_prio[1] = 10;
        tick();
        s_vld[1] = 0;
        start = cnt_g1;
        for (int i = 0; i < 260; i++) begin
            tick();
            if (cnt_g1 > start) break;
        end
        chk("ch1_wins", (cnt_g1 > start) ? 1 : 0, 1);
        clr_vld();
        repeat (8) tick();

        // Stale and out-of-range results are dropped.
        arb_mode = 1;
        foreach (pv[i]) pv[i] = 0;
        for (int j = 0; j < 4; j++) begin
            o_vld = 1; o_gnt = (j == 0) ? 3 : (j == 1) ? 4 : (j == 2) ? 5 : 7;
            tick();
            chk($sformatf("stale_drop_%0d", o_gnt), int'(bus.drop), 1);
            o_vld = 0;
            tick();
            chk("drop_one_cycle", int'(bus.drop), 0);
        end

        // Backpressure: busy slot drops a valid grant; ch1 keeps aging.
        s_rdy = 0;
        s_vld[0] = 1; s_prio[0] = 50;
        s_vld[1] = 1; s_prio[1] = 60;
        tick();
        clr_vld();
        tick();
        o_vld = 1; o_gnt = 0;
        tick();
        o_gnt = 1;
        tick();
        chk("bp_drop", int'(bus.drop), 1);
        chk("bp_hold_idx", int'(bus.gnt_idx), 0);
        chk("bp_ch1_pending", int'(bus.arb_req[1]), 1);
        o_vld = 0;
        repeat (2) tick();
        s_rdy = 1; o_vld = 1; o_gnt = 1;
        tick();
        chk("bp_take_ch1", int'(bus.gnt_idx), 1);
        o_vld = 0;
        repeat (4) tick();

        // Back-to-back grants 0..3.
        for (int k = 0; k < 4; k++) begin
            s_vld[k] = 1; s_prio[k] = int'($urandom_range(0, 255));
        end
        tick();
        clr_vld();
        tick();
        for (int k = 0; k < 4; k++) begin
            o_vld = 1; o_gnt = k;
            tick();
            chk("b2b_vld", int'(bus.gnt_vld), 1);
            chk("b2b_idx", int'(bus.gnt_idx), k);
        end
        o_vld = 0;
        repeat (4) tick();

        // Mid-operation reset, then in-flight results all drop.
        for (int k = 0; k < 4; k++) begin
            s_vld[k] = 1; s_prio[k] = 30 + k;
        end
        tick();
        clr_vld();
        tick();
        s_rst = 1;
        tick();
        s_rst = 0;
        chk("rst_arb_req", int'(bus.arb_req), 0);
        chk("rst_rdy_all", int'(bus.req_rdy), (1 << DCNT) - 1);
        for (int k = 0; k < 4; k++) begin
            o_vld = 1; o_gnt = k;
            tick();
            chk("rst_stale_drop", int'(bus.drop), 1);
        end
        o_vld = 0;
        tick();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < DCNT; k++) begin
                s_vld[k]  = ($urandom_range(0, 2) == 0) ? 1 : 0;
                s_prio[k] = int'($urandom_range(0, 255));
            end
            s_rdy = ($urandom_range(0, 3) != 0) ? 1 : 0;
            s_rst = ($urandom_range(0, 299) == 0) ? 1 : 0;
            r = int'($urandom_range(0, 9));
            if (r < 6) arb_mode = 0;
            else if (r < 8) begin
                arb_mode = 1; o_vld = 1; o_gnt = int'($urandom_range(0, 7));
            end else arb_mode = 2;
            tick();
        end

        clr_vld();
        s_rst = 0; s_rdy = 1; arb_mode = 2;
        repeat (6) tick();
        chk("sb_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cm_arb_agent.md
# cm_arb_agent

Requester-side agent for the weighted max-priority arbiter in lib_cm. It collects one pending request per channel from upstream valid/ready ports and drives the arbiter's request/weight vector. Waiting weights age so starved channels eventually win. It consumes the arbiter's valid/grant-index result, discards stale grants caused by arbiter pipeline latency, and presents each accepted grant downstream on a valid/ready port.

## Interface
- DCNT, 4: channel count (≥2)
- DWIDTH, 8: weight width
- REG_CNT, 2: latency of the attached arbiter in cycles (≥0), sizes the re-request holdoff
- AGE_STEP, 1: weight increment per waiting cycle (≥0; 0 disables aging)
- IDX_WIDTH (localparam), sclog2(DCNT): grant index width

- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_req_vld  in  DCNT  per-channel request valid
- o_req_rdy  out  DCNT  per-channel request ready
- i_req_prio  in  DCNT×DWIDTH  initial weight per channel, sampled on accept
- o_arb_req  out  DCNT  request vector to arbiter
- o_arb_weight  out  DCNT×DWIDTH  current aged weight per channel
- i_arb_vld  in  1  arbiter result valid
- i_arb_gnt  in  IDX_WIDTH  arbiter granted index
- o_gnt_vld  out  1  grant valid downstream
- o_gnt_idx  out  IDX_WIDTH  granted channel index
- o_gnt_onehot  out  DCNT  one-hot of o_gnt_idx, zero when !o_gnt_vld
- i_gnt_rdy  in  1  downstream accepts grant
- o_drop  out  1  one-cycle pulse: an arbiter result was discarded

## Operation
- Per-channel state: pending[k], weight[k] (DWIDTH), holdoff[k] (counter 0..REG_CNT).
- o_req_rdy[k] = !pending[k] && holdoff[k]==0. On accept (i_req_vld[k] && o_req_rdy[k]): pending[k]<=1, weight[k]<=i_req_prio[k].
- o_arb_req = pending; o_arb_weight = weight (combinational from registers).
- Aging: every cycle pending[k] and k is not being granted, weight[k] <= min(weight[k]+AGE_STEP, 2^DWIDTH-1). Saturating, never wraps.
- Output slot free when !o_gnt_vld || i_gnt_rdy.
- Grant acceptance, when i_arb_vld with k=i_arb_gnt:
  - Taken when k<DCNT, pending[k], and slot free. Then o_gnt_vld<=1, o_gnt_idx<=k, pending[k]<=0, weight[k]<=0, holdoff[k]<=REG_CNT.
  - Otherwise (not pending, index out of range, slot busy): o_drop<=1. State is unchanged and a pending channel stays pending and keeps aging.
- Slot drains: o_gnt_vld && i_gnt_rdy and no new grant taken → o_gnt_vld<=0. Drain and new take in the same cycle are allowed (back-to-back).
- holdoff[k] decrements by 1 per cycle while nonzero. It blocks re-acceptance until no in-flight arbiter result can refer to the previous request of k.
- Designed for ARB_MAX arbitration; ties between equal weights are resolved by the arbiter, not by the agent.

## Timing
- Reset: pending, weight, holdoff = 0. o_req_rdy = all ones on the first cycle after reset. o_arb_req=0, o_arb_weight=0, o_gnt_vld=0, o_gnt_idx=0, o_gnt_onehot=0, o_drop=0.
- Accept at cycle t → o_arb_req[k]=1 with weight i_req_prio at t+1, weight+AGE_STEP at t+2, and so on.
- Grant take at cycle g → o_gnt_vld at g+1. o_arb_req[k]=0 at g+1. o_req_rdy[k] returns high at g+REG_CNT+1 (REG_CNT=0: g+1).
- o_drop registered: asserted the cycle after the discarded result, for one cycle.
- o_gnt_vld/o_gnt_idx hold stable while !i_gnt_rdy.
- Reset mid-operation clears all state at the next edge. Outstanding arbiter results after reset target non-pending channels and are dropped.
- Min request-to-grant latency: accept t, arbiter sees t+1, result at t+1+REG_CNT, o_gnt_vld at t+2+REG_CNT.

## Test plan
- Reset then single request: DCNT=4, REG_CNT=2, ch2 prio=5 at cycle 0, arbiter model grants 2 at cycle 3 → o_gnt_vld=1, o_gnt_idx=2, onehot=0100 at cycle 4. o_req_rdy[2] low until cycle 6.
- Aging/starvation: ch0 prio=200 held, ch1 prio=10, AGE_STEP=1, DWIDTH=8. ch0 is re-requested whenever ready. Ch1 weight saturates at 255, never 0 after wrap, and ch1 wins within 246 cycles.
- Stale grant: grant for ch3 while pending[3]=0 → o_drop pulses 1 cycle, o_gnt_vld unchanged. Repeat with index 5 for DCNT=5 and index 7 → drop.
- Backpressure: o_gnt_vld=1, i_gnt_rdy=0, new grant for pending ch1 → dropped. ch1 stays pending and its weight keeps incrementing. After i_gnt_rdy=1 the next grant for ch1 is taken.
- Back-to-back: i_gnt_rdy=1 constantly, grants 0,1,2,3 on consecutive cycles for pending channels → four consecutive o_gnt_vld cycles, indices 0,1,2,3.
- Mid-op reset: pending 1111, i_rst for one cycle → all state zero next cycle. Grants 0..3 in the following REG_CNT cycles each produce o_drop.
